mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//   E-stage multiply/divide unit: executes the MDUOp commands issued by the decoder
//   (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) and owns the architectural HI/LO registers.
//   Models multi-cycle latency with a busy counter; start|busy drives the hazard unit,
//   which stalls D-stage md/mt/mf instructions. MDU_out feeds the RF write-data mux (type MDU_out).
// PARAMETERS
//   WIDTH        32  operand / HI / LO width
//   MULT_CYCLES  5   busy cycles for mult/multu
//   DIV_CYCLES   10  busy cycles for div/divu
// PORTS
//   clk      in   1      single clock; all state on rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   req      in   1      E-stage instruction valid (0 on bubble/flush)
//   MDUOp    in   4      1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; 0/9-15 no-op
//   A        in   WIDTH  forwarded rs value
//   B        in   WIDTH  forwarded rt value
//   start    out  1      combinational: req & MDUOp in {1..4} & !busy
//   busy     out  1      registered: multi-cycle op in flight
//   MDU_out  out  WIDTH  combinational: HI when MDUOp==5, LO when MDUOp==6, else 0
//   HI       out  WIDTH  architectural HI (debug/trace)
//   LO       out  WIDTH  architectural LO (debug/trace)
// BEHAVIOUR
//   Reset (async, rst_n=0): busy=0, counter=0, HI=LO=0, pending regs=0; in-flight op abandoned.
//   States: IDLE (busy=0) and RUN (busy=1, counter>0).
//   IDLE + start in cycle t: compute result into hi_pend/lo_pend, counter<=N (MULT_CYCLES or
//     DIV_CYCLES), busy<=1. busy=1 in cycles t+1..t+N; at end of t+N HI<=hi_pend, LO<=lo_pend,
//     busy<=0. New HI/LO visible from t+N+1. Back-to-back start is legal in t+N+1.
//   RUN: counter decrements each cycle; commit when counter==1.
//   mult:  {HI,LO} = $signed(A)*$signed(B), 64-bit.  multu: unsigned 64-bit product.
//   div:   LO = signed quotient (truncate toward zero), HI = remainder (sign of dividend);
//          0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   divu:  LO = A/B, HI = A%B (unsigned).
//   B==0 on div/divu: full DIV_CYCLES busy period, HI/LO left unchanged at commit.
//   mthi/mtlo with req & !busy: HI<=A / LO<=A at next edge, single cycle, no busy.
//   mthi/mtlo/md issued with busy=1: ignored, state untouched (hazard unit must prevent;
//     bench flags as protocol error).
//   mfhi/mflo: pure read, no state change; value reflects last committed HI/LO.
//   req=0: no state change except RUN counting continues.
//   Flush of E stage after start has fired does NOT cancel the op (MIPS semantics).
//   No-op codes (0, 9-15): start=0, MDU_out=0, no state change.
// STRUCTURE
//   Shared package mdu_pkg: MDUOp encodings (MDU_MULT..MDU_MTLO), MULT_CYCLES/DIV_CYCLES
//     defaults, and the is_md(op) helper used by both the decoder and the hazard unit.
//   No sub-module: one counter/FSM process plus combinational 64-bit arithmetic.
//   Arithmetic computed at issue; only the counter models latency.
// TESTING
//   1 mult A=0xFFFFFFFF B=2 -> start=1 one cycle, busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
//   2 multu A=0xFFFFFFFF B=2 -> HI=0x00000001 LO=0xFFFFFFFE after 5 busy cycles.
//   3 div A=0xFFFFFFF9(-7) B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF;
//     divu A=7 B=0 -> busy 10 cycles, HI/LO unchanged.
//   4 mthi A=0x12345678 then mfhi next cycle -> MDU_out=0x12345678, busy stays 0;
//     mtlo A=0xCAFE0000 -> LO=0xCAFE0000 after one edge.
//   5 divu issued, rst_n low on 4th busy cycle -> busy=0, HI=LO=0 immediately;
//     no commit after rst_n rises.
//   6 mult issued, mtlo/div with req=1 during busy -> start=0, HI/LO equal mult result
//     only; divu issued the cycle busy falls -> start=1, accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: MDUOp encodings, latencies
// and the is_md() helper shared with the decoder and hazard unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    function automatic logic is_md(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; results are computed at issue
// and committed after a busy period that models multi-cycle latency.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] MDU_out,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    import mdu_pkg::*;

    localparam int NMAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);
    localparam int W2   = 2 * WIDTH;

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic           commit, busy_w, start_w, is_div;

    logic [W2-1:0]    prod_s, prod_u;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, bs_div, bu_div;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign busy_w  = (state_q == S_RUN);
    assign start_w = req & is_md(MDUOp) & ~busy_w;
    assign is_div  = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);

    // Divide on magnitudes so the quotient truncates toward zero and the
    // remainder follows the dividend; divisor forced to 1 when B is zero.
    always_comb begin
        prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        a_neg  = A[WIDTH-1];
        b_neg  = B[WIDTH-1];
        b_zero = (B == '0);
        a_mag  = a_neg ? ('0 - A) : A;
        b_mag  = b_neg ? ('0 - B) : B;
        bs_div = b_zero ? WIDTH'(1) : b_mag;
        bu_div = b_zero ? WIDTH'(1) : B;
        q_mag  = a_mag / bs_div;
        r_mag  = a_mag % bs_div;
        q_s    = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
        r_s    = a_neg ? ('0 - r_mag) : r_mag;
        q_u    = A / bu_div;
        r_u    = A % bu_div;
    end

    always_comb begin
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        if (start_w) begin
            unique case (1'b1)
                MDUOp == MDU_MULT:  {hi_pend_d, lo_pend_d} = prod_s;
                MDUOp == MDU_MULTU: {hi_pend_d, lo_pend_d} = prod_u;
                MDUOp == MDU_DIV:
                    {hi_pend_d, lo_pend_d} = b_zero ? {hi_q, lo_q} : {r_s, q_s};
                MDUOp == MDU_DIVU:
                    {hi_pend_d, lo_pend_d} = b_zero ? {hi_q, lo_q} : {r_u, q_u};
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d = S_RUN;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
        end else if (req && !busy_w && MDUOp == MDU_MTHI) begin
            hi_d = A;
        end else if (req && !busy_w && MDUOp == MDU_MTLO) begin
            lo_d = A;
        end
    end

    always_comb begin
        start   = start_w;
        busy    = busy_w;
        MDU_out = '0;
        HI      = hi_q;
        LO      = lo_q;
        if (MDUOp == MDU_MFHI)
            MDU_out = hi_q;
        else if (MDUOp == MDU_MFLO)
            MDU_out = lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: random and directed ops checked against
// a plain-arithmetic HI/LO model; commits checked when busy falls.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        start, busy;
    logic [31:0] mdu_out, hi, lo;

    always #5 clk = ~clk;

    mdu_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .MDUOp(op),
        .A(a), .B(b), .start(start), .busy(busy),
        .MDU_out(mdu_out), .HI(hi), .LO(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    task automatic ref_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          inout logic [31:0] h, inout logic [31:0] l);
        longint      ps;
        logic [63:0] pu;
        int          sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            4'd1: begin ps = longint'(sx) * longint'(sy); {h, l} = ps; end
            4'd2: begin pu = {32'b0, x} * {32'b0, y}; {h, l} = pu; end
            4'd3: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = x; h = 0;
                end else begin
                    l = sx / sy; h = sx % sy;
                end
            end
            4'd4: if (y != 0) begin l = x / y; h = x % y; end
            default: ;
        endcase
    endtask

    // Monitor: every busy->0 transition is a commit that pops one expectation.
    int   blen = 0;
    logic bprev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            blen = 0;
            bprev = 1'b0;
        end else begin
            if (busy) begin
                blen++;
            end else if (bprev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got commit expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_hi", 64'(hi), 64'(e.hi));
                    chk("commit_lo", 64'(lo), 64'(e.lo));
                    chk("busy_len", 64'(blen), 64'(e.cyc));
                end
                blen = 0;
            end
            bprev = busy;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic r, output logic st, output logic [31:0] mo);
        @(negedge clk);
        req = r; op = o; a = x; b = y;
        #1;
        st = start;
        mo = mdu_out;
        @(posedge clk);
        #1;
        req = 1'b0; op = 4'd0;
    endtask

    task automatic push_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        ref_md(o, x, y, m_hi, m_lo);
        e.hi = m_hi;
        e.lo = m_lo;
        e.cyc = (o <= 4'd2) ? MULT_CYCLES : DIV_CYCLES;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic st;
        logic [31:0] mo;
        push_md(o, x, y);
        issue(o, x, y, 1'b1, st, mo);
        chk("start", 64'(st), 64'd1);
        wait_idle();
    endtask

    task automatic run_mt(input logic [3:0] o, input logic [31:0] x);
        logic st;
        logic [31:0] mo;
        issue(o, x, 32'h0, 1'b1, st, mo);
        if (o == 4'd7) m_hi = x; else m_lo = x;
        chk("mt_start", 64'(st), 64'd0);
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
        chk("mt_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_mf(input logic [3:0] o);
        logic st;
        logic [31:0] mo;
        issue(o, $urandom, $urandom, 1'b1, st, mo);
        chk("mf_out", 64'(mo), 64'((o == 4'd5) ? m_hi : m_lo));
    endtask

    initial begin
        logic        st;
        logic [31:0] mo, x, y;
        int          k;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_md(4'd1, 32'hFFFF_FFFF, 32'd2);
        run_md(4'd2, 32'hFFFF_FFFF, 32'd2);
        run_md(4'd3, 32'hFFFF_FFF9, 32'd2);
        run_md(4'd4, 32'd7, 32'd0);
        run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

        run_mt(4'd7, 32'h1234_5678);
        run_mf(4'd5);
        run_mt(4'd8, 32'hCAFE_0000);
        run_mf(4'd6);

        issue(4'd12, 32'h5, 32'h6, 1'b1, st, mo);
        chk("nop_start", 64'(st), 64'd0);
        chk("nop_out", 64'(mo), 64'd0);
        issue(4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0, st, mo);
        chk("bubble_hi", 64'(hi), 64'(m_hi));
        issue(4'd1, 32'h3, 32'h3, 1'b0, st, mo);
        chk("bubble_start", 64'(st), 64'd0);

        // Ops issued while busy are ignored; divu taken in the cycle busy falls.
        push_md(4'd1, 32'h0001_2345, 32'hFFFF_0000);
        issue(4'd1, 32'h0001_2345, 32'hFFFF_0000, 1'b1, st, mo);
        chk("busy_start", 64'(st), 64'd1);
        issue(4'd8, 32'hDEAD_0000, 32'h0, 1'b1, st, mo);
        chk("busy_mt_start", 64'(st), 64'd0);
        issue(4'd3, 32'd100, 32'd3, 1'b1, st, mo);
        chk("busy_div_start", 64'(st), 64'd0);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        req = 1'b1; op = 4'd4; a = 32'd1000; b = 32'd7;
        #1;
        chk("b2b_start", 64'(start), 64'd1);
        push_md(4'd4, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        req = 1'b0; op = 4'd0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(1, 9);
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = $urandom_range(1, 9);
                2: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if (k <= 4) run_md(4'(k), x, y);
            else if (k <= 6) run_mf(4'(k));
            else if (k <= 8) run_mt(4'(k), x);
            else begin
                issue(4'(k), x, y, 1'b0, st, mo);
                chk("rand_bubble_hi", 64'(hi), 64'(m_hi));
            end
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        run_mt(4'd7, 32'h0BAD_F00D);
        run_mt(4'd8, 32'h0F00_BA44);
        issue(4'd4, 32'd100, 32'd7, 1'b1, st, mo);
        chk("rst_case_start", 64'(st), 64'd1);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
